icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the PC/IF logic and the instruction ROM.
- Serves instruction fetch in the IF stage and drives the fetch-ready flag used to hold the pipeline on a miss.
- On a miss it refills one line word-by-word from the ROM over a req/valid beat handshake, then serves the fetch.
- Has an invalidate input so a fence.i-style event can discard all lines.

---
 rtl/icache_direct.sv | 163 ++++++++++++++++
 tb/tb_icache_direct.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache between IF and the ROM.
// A hit returns the instruction in the same cycle. A miss refills the whole line
// one word at a time over a req/rvalid handshake, and then the fetch is served.
// Optional statistics counters are built when the ICACHE_STATS_EN macro is defined.
//
// Ports:
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   pc_i           fetch address; bits [1:0] are ignored
//   fetch_req_i    a fetch is valid this cycle
//   invalidate_i   one-cycle pulse that discards all lines
//   instr_o        fetched instruction; NOP when ready_o=0
//   ready_o        hit on pc_i this cycle
//   mem_req_o      ROM word request, held until accepted
//   mem_addr_o     word-aligned ROM address
//   mem_rdata_i    ROM data
//   mem_rvalid_i   ROM beat done; accepts the current request
//   hit_count_o    (ICACHE_STATS_EN) saturating count of served fetches
//   miss_count_o   (ICACHE_STATS_EN) saturating count of refills started
module icache_direct #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2,
    localparam int TAG_BITS   = 32 - 2 - OFFSET_BITS - INDEX_BITS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        fetch_req_i,
    input  logic        invalidate_i,
    output logic [31:0] instr_o,
    output logic        ready_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            base_q, base_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic                   inv_pend_q, inv_pend_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [31:0]            data_q [LINES][WORDS];

    logic [OFFSET_BITS-1:0] off;
    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  ref_idx;
    logic [TAG_BITS-1:0]    ref_tag;
    logic                   hit;
    logic                   refill_we;
    logic                   unused_pc;

    assign off       = pc_i[OFFSET_BITS+1:2];
    assign idx       = pc_i[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
    assign tag       = pc_i[31:32-TAG_BITS];
    assign ref_idx   = base_q[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
    assign ref_tag   = base_q[31:32-TAG_BITS];
    assign unused_pc = ^pc_i[1:0];

    // A fetch that coincides with an invalidate is not served.
    assign hit = fetch_req_i && (state_q == S_IDLE) && !invalidate_i &&
                 valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        inv_pend_d = inv_pend_q;
        valid_d    = valid_q;
        ready_o    = hit;
        instr_o    = hit ? data_q[idx][off] : NOP;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        refill_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (invalidate_i) begin
                    valid_d = '0;
                end else if (fetch_req_i && !hit) begin
                    state_d = S_REFILL;
                    base_d  = {pc_i[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
                    cnt_d   = '0;
                end
            end
            S_REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {base_q[31:OFFSET_BITS+2], cnt_q, 2'b00};
                if (invalidate_i) inv_pend_d = 1'b1;
                if (mem_rvalid_i) begin
                    refill_we = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == OFFSET_BITS'(WORDS - 1)) begin
                        valid_d[ref_idx] = 1'b1;
                        state_d          = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A deferred invalidate also discards the line just installed.
                state_d = S_IDLE;
                if (inv_pend_q || invalidate_i) valid_d = '0;
                inv_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            inv_pend_q <= inv_pend_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && refill_we) begin
            data_q[ref_idx][cnt_q] <= mem_rdata_i;
            if (cnt_q == OFFSET_BITS'(WORDS - 1)) tag_q[ref_idx] <= ref_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (fetch_req_i && ready_o && (hit_cnt_q != 32'hFFFF_FFFF))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if ((state_q == S_IDLE) && (state_d == S_REFILL) && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        fetch_req = 1'b0;
    logic        invalidate = 1'b0;
    logic [31:0] instr;
    logic        ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    icache_direct dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pc_i         (pc),
        .fetch_req_i  (fetch_req),
        .invalidate_i (invalidate),
        .instr_o      (instr),
        .ready_o      (ready),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .mem_rvalid_i (mem_rvalid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: which 16-byte line each of the 16 slots holds.
    logic [31:0] m_base [16];
    bit          m_valid [16];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int slot = int'(a[7:4]);
        return m_valid[slot] && (m_base[slot] == {a[31:4], 4'b0});
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            nxt();
            fetch_req  = 1'b0;
            mem_rvalid = 1'b0;
            invalidate = 1'b0;
        end
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1; fetch_req = 1'b0; mem_rvalid = 1'b0; invalidate = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_instr", instr, NOP);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        model_clear();
        m_hits = 0;
        m_misses = 0;
`ifdef ICACHE_STATS_EN
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
`endif
    endtask

    // One fetch of address a. On a miss the bench plays the ROM with per-beat
    // delays in [dmin,dmax]; inv_beat pulses invalidate on that beat, rst_after
    // resets the cache in the cycle after that beat.
    task automatic do_fetch(input logic [31:0] a, input int dmin, input int dmax,
                            input int inv_beat, input int rst_after);
        logic [31:0] base;
        logic [31:0] ea;
        int d;
        base = {a[31:4], 4'b0};
        nxt();
        pc = a; fetch_req = 1'b1; mem_rvalid = 1'b0; invalidate = 1'b0;
        #1;
        if (model_hit(a)) begin
            chk("hit_ready", 32'(ready), 1);
            chk("hit_instr", instr, rom(a));
            chk("hit_no_req", 32'(mem_req), 0);
            m_hits++;
            return;
        end
        chk("miss_ready", 32'(ready), 0);
        chk("miss_instr", instr, NOP);
        m_misses++;
        for (int beat = 0; beat < 4; beat++) begin
            ea = base + 32'(4 * beat);
            d = int'($urandom_range(dmax, dmin));
            for (int s = 0; s < d; s++) begin
                nxt();
                mem_rvalid = 1'b0; invalidate = 1'b0; pc = $urandom;
                #1;
                chk("stall_req", 32'(mem_req), 1);
                chk("stall_addr", mem_addr, ea);
                chk("refill_ready", 32'(ready), 0);
            end
            nxt();
            mem_rvalid = 1'b1; mem_rdata = rom(ea); invalidate = (beat == inv_beat);
            pc = $urandom;
            #1;
            chk("beat_req", 32'(mem_req), 1);
            chk("beat_addr", mem_addr, ea);
            if (beat == rst_after) begin
                nxt();
                mem_rvalid = 1'b0; invalidate = 1'b0; rst = 1'b1; fetch_req = 1'b0;
                nxt();
                rst = 1'b0;
                #1;
                chk("midrst_req", 32'(mem_req), 0);
                chk("midrst_ready", 32'(ready), 0);
                model_clear();
                m_hits = 0;
                m_misses = 0;
                return;
            end
        end
        nxt();
        mem_rvalid = 1'b0; invalidate = 1'b0; pc = a;
        #1;
        chk("done_ready", 32'(ready), 0);
        chk("done_instr", instr, NOP);
        chk("done_req", 32'(mem_req), 0);
        if (inv_beat >= 0 && inv_beat < 4) model_clear();
        else begin
            m_base[int'(a[7:4])]  = base;
            m_valid[int'(a[7:4])] = 1'b1;
        end
        nxt();
        if (inv_beat >= 0 && inv_beat < 4) begin
            fetch_req = 1'b0;
            #1;
            chk("postinv_ready", 32'(ready), 0);
            chk("postinv_req", 32'(mem_req), 0);
        end else begin
            #1;
            chk("fill_ready", 32'(ready), 1);
            chk("fill_instr", instr, rom(a));
            m_hits++;
        end
    endtask

    // Invalidate pulse in IDLE while a fetch is presented: that fetch is not served.
    task automatic inv_idle(input logic [31:0] a);
        nxt();
        pc = a; fetch_req = 1'b1; invalidate = 1'b1; mem_rvalid = 1'b0;
        #1;
        chk("inv_idle_ready", 32'(ready), 0);
        chk("inv_idle_instr", instr, NOP);
        nxt();
        invalidate = 1'b0; fetch_req = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // cold miss, ROM answers one cycle after each request, then hits
        do_fetch(32'h00, 1, 1, -1, -1);
        do_fetch(32'h04, 0, 0, -1, -1);
        do_fetch(32'h08, 0, 0, -1, -1);
        idle(1);
        #1;
`ifdef ICACHE_STATS_EN
        chk("stats_hit_3", hit_count, 3);
        chk("stats_miss_1", miss_count, 1);
`endif
        chk("idle_ready", 32'(ready), 0);

        // conflict eviction on index 0
        do_fetch(32'h100, 0, 2, -1, -1);
        do_fetch(32'h10C, 0, 0, -1, -1);
        do_fetch(32'h04, 0, 2, -1, -1);
        do_fetch(32'h0C, 0, 0, -1, -1);

        // stalled ROM, then read the whole line back
        do_fetch(32'h40, 0, 5, -1, -1);
        do_fetch(32'h44, 0, 0, -1, -1);
        do_fetch(32'h48, 0, 0, -1, -1);
        do_fetch(32'h4C, 0, 0, -1, -1);

        // stray rvalid in IDLE is ignored
        idle(1);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("stray_rvalid_req", 32'(mem_req), 0);
        idle(1);
        do_fetch(32'h44, 0, 0, -1, -1);

        // invalidate in IDLE
        inv_idle(32'h00);
        do_fetch(32'h00, 0, 1, -1, -1);

        // invalidate during refill beat 2
        do_fetch(32'h80, 0, 2, 2, -1);
        do_fetch(32'h80, 0, 1, -1, -1);

        // reset after beat 1, then a full refill of the same line
        do_fetch(32'h20, 0, 1, -1, 1);
        do_fetch(32'h20, 0, 1, -1, -1);
        do_fetch(32'h2C, 0, 0, -1, -1);

        // random traffic over a small window so hits, misses and conflicts mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(15, 0) == 0) inv_idle({22'b0, 8'($urandom), 2'b0});
            do_fetch({22'b0, 8'($urandom_range(255, 0)), 2'b0}, 0, 3, -1, -1);
        end

        idle(1);
        #1;
`ifdef ICACHE_STATS_EN
        chk("stats_hit_total", hit_count, 32'(m_hits));
        chk("stats_miss_total", miss_count, 32'(m_misses));
`endif
        chk("final_req", 32'(mem_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
